// File: rtl/mlp_pkg.sv
// Shared types for the time-multiplexed dense layer.
// Provides the datapath word, the ReLU helper and the FSM state enum.
package mlp_pkg;

  localparam int NBITS = 16;

  typedef logic [NBITS-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // A negative two's-complement value clamps to zero.
  function automatic word_t relu(input word_t v);
    return v[NBITS-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/mlp_mac.sv
// Shared multiply-accumulate unit with a bias/ReLU finish step.
// Ports: a_i/b_i operands, en_i accumulate a*b, bias_en_i finish with bias b_i
// (acc cleared on the same edge), clr_i synchronous clear, y_o = relu(acc+b_i).
module mlp_mac
  import mlp_pkg::*;
(
  input  logic  clk,
  input  word_t a_i,
  input  word_t b_i,
  input  logic  en_i,
  input  logic  bias_en_i,
  input  logic  clr_i,
  output word_t y_o
);

  word_t acc_q;
  word_t acc_d;
  word_t prod;

  // All arithmetic wraps at the word width.
  assign prod = a_i * b_i;
  assign y_o  = relu(acc_q + b_i);

  always_comb begin
    acc_d = acc_q;
    if (bias_en_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/dense_layer_sequencer.sv
// Dense layer, one MAC reused: dout[j] = relu(sum_i din[i]*W[i][j] + b[j]).
// Ports: in_* valid/ready vector input, w_*/b_* synchronous weight and bias
// memory reads (data one cycle after strobe), out_* valid/ready result, busy.
module dense_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int NBits = NBITS,
  parameter int D1    = 4,
  parameter int D2    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [D1-1:0][NBits-1:0]       in_data,
  output logic                           w_rd_en,
  output logic [$clog2(D1*D2)-1:0]       w_addr,
  input  logic [NBits-1:0]               w_rdata,
  output logic                           b_rd_en,
  output logic [$clog2(D2)-1:0]          b_addr,
  input  logic [NBits-1:0]               b_rdata,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [D2-1:0][NBits-1:0]       out_data,
  output logic                           busy
);

  localparam int AW = $clog2(D1*D2);
  localparam int BW = $clog2(D2);
  localparam int KW = $clog2(D1+1);
  localparam int IW = (D1 > 1) ? $clog2(D1) : 1;

  localparam logic [KW-1:0] K_BIAS  = KW'(D1);
  localparam logic [KW-1:0] K_LASTW = KW'(D1-1);
  localparam logic [BW-1:0] J_LAST  = BW'(D2-1);

  state_e                   state_q;
  logic [KW-1:0]            k_q;
  logic [BW-1:0]            j_q;
  logic [D1-1:0][NBits-1:0] x_q;
  logic                     w_rd_en_q;
  logic                     b_rd_en_q;
  logic [AW-1:0]            w_addr_q;
  logic [BW-1:0]            b_addr_q;
  logic                     out_valid_q;

  logic                     w_ret_q;
  logic                     b_ret_q;
  logic [IW-1:0]            k_ret_q;
  logic [BW-1:0]            j_ret_q;
  logic [D2-1:0][NBits-1:0] out_q;

  word_t mac_b;
  word_t mac_y;

  // Ready is forced low while reset is held so nothing is
  // accepted on the reset edge itself.
  assign in_ready  = (state_q == IDLE) & ~rst;
  assign busy      = (state_q != IDLE);
  assign w_rd_en   = w_rd_en_q;
  assign w_addr    = w_addr_q;
  assign b_rd_en   = b_rd_en_q;
  assign b_addr    = b_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      j_q         <= '0;
      x_q         <= '0;
      w_rd_en_q   <= 1'b0;
      b_rd_en_q   <= 1'b0;
      w_addr_q    <= '0;
      b_addr_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q       <= in_data;
            k_q       <= '0;
            j_q       <= '0;
            w_rd_en_q <= 1'b1;
            w_addr_q  <= '0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (k_q == K_BIAS) begin
            // Bias issue ends a column; next column starts
            // immediately with its row-0 weight.
            b_rd_en_q <= 1'b0;
            if (j_q == J_LAST) begin
              state_q <= DRAIN;
            end else begin
              j_q       <= j_q + 1'b1;
              k_q       <= '0;
              w_rd_en_q <= 1'b1;
              w_addr_q  <= AW'(j_q + 1'b1);
            end
          end else begin
            k_q <= k_q + 1'b1;
            if (k_q == K_LASTW) begin
              w_rd_en_q <= 1'b0;
              b_rd_en_q <= 1'b1;
              b_addr_q  <= j_q;
            end else begin
              w_addr_q <= w_addr_q + AW'(D2);
            end
          end
        end
        DRAIN: begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Return stage trails the issue stage by one cycle, matching
  // the memory read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ret_q <= 1'b0;
      b_ret_q <= 1'b0;
      k_ret_q <= '0;
      j_ret_q <= '0;
      out_q   <= '0;
    end else begin
      w_ret_q <= w_rd_en_q;
      b_ret_q <= b_rd_en_q;
      k_ret_q <= IW'(k_q);
      j_ret_q <= j_q;
      if (b_ret_q) begin
        out_q[j_ret_q] <= mac_y;
      end
    end
  end

  assign mac_b = b_ret_q ? b_rdata : w_rdata;

  mlp_mac u_mac (
    .clk      (clk),
    .a_i      (x_q[k_ret_q]),
    .b_i      (mac_b),
    .en_i     (w_ret_q),
    .bias_en_i(b_ret_q),
    .clr_i    (rst),
    .y_o      (mac_y)
  );

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// Directed bench for dense_layer_sequencer with a result scoreboard.
// Models the weight/bias memories and an independent reference layer.
module tb_dense_layer_sequencer;

  localparam int NB = 16;
  localparam int D1 = 4;
  localparam int D2 = 4;
  localparam int N  = D2 * (D1 + 1);

  typedef logic [D1-1:0][NB-1:0] vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  vec_t        in_data = '0;
  logic        w_rd_en;
  logic [3:0]  w_addr;
  logic [NB-1:0] w_rdata = '0;
  logic        b_rd_en;
  logic [1:0]  b_addr;
  logic [NB-1:0] b_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  vec_t        out_data;
  logic        busy;

  logic [NB-1:0] wmem [D1*D2];
  logic [NB-1:0] bmem [D2];

  vec_t sb [$];
  vec_t last_out;
  vec_t v;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dense_layer_sequencer #(.NBits(NB), .D1(D1), .D2(D2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .w_rd_en  (w_rd_en),
    .w_addr   (w_addr),
    .w_rdata  (w_rdata),
    .b_rd_en  (b_rd_en),
    .b_addr   (b_addr),
    .b_rdata  (b_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  // Synchronous memories; junk is returned when not strobed.
  always @(posedge clk) begin
    if (w_rd_en) w_rdata <= wmem[w_addr];
    else w_rdata <= NB'($urandom);
    if (b_rd_en) b_rdata <= bmem[b_addr];
    else b_rdata <= NB'($urandom);
  end

  function automatic vec_t ref_dense(input vec_t x);
    vec_t o;
    logic [NB-1:0] acc;
    logic [NB-1:0] r;
    for (int j = 0; j < D2; j++) begin
      acc = '0;
      for (int i = 0; i < D1; i++) begin
        acc = acc + NB'(x[i] * wmem[i*D2+j]);
      end
      r = acc + bmem[j];
      o[j] = r[NB-1] ? '0 : r;
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_w(input int kind);
    for (int i = 0; i < D1; i++)
      for (int j = 0; j < D2; j++)
        wmem[i*D2+j] = (kind == 0) ? NB'(i == j) :
                       (kind == 1) ? NB'(1) : NB'($urandom);
  endtask

  // Starts at a negedge with the DUT idle; returns at the negedge
  // one cycle after the result handshake.
  task automatic run_vec(input vec_t x, input int hold);
    int n;
    int idx;
    int jj;
    int kk;
    bit seen;
    vec_t exp_v;
    chk("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    in_data   = x;
    out_ready = (hold == 0);
    sb.push_back(ref_dense(x));
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '1;
    n = 1;
    seen = 0;
    while (!seen && n < 60) begin
      if (out_valid) begin
        seen = 1;
      end else begin
        if (n <= N) begin
          idx = n - 1;
          jj  = idx / (D1 + 1);
          kk  = idx % (D1 + 1);
          if (kk < D1) begin
            chk("w_rd_en", w_rd_en, 1);
            chk("b_rd_en", b_rd_en, 0);
            chk("w_addr", w_addr, kk*D2 + jj);
          end else begin
            chk("w_rd_en", w_rd_en, 0);
            chk("b_rd_en", b_rd_en, 1);
            chk("b_addr", b_addr, jj);
          end
        end else begin
          chk("drain_w_rd_en", w_rd_en, 0);
          chk("drain_b_rd_en", b_rd_en, 0);
        end
        chk("run_in_ready", in_ready, 0);
        chk("run_busy", busy, 1);
        @(negedge clk);
        n++;
      end
    end
    chk("latency", n, N + 2);
    if (seen) begin
      exp_v = sb.pop_front();
      for (int h = 0; h < hold; h++) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, exp_v);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_strobes", {w_rd_en, b_rd_en}, 0);
        @(negedge clk);
      end
      out_ready = 1'b1;
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, exp_v);
      last_out = out_data;
      @(negedge clk);
      chk("post_valid", out_valid, 0);
      chk("post_in_ready", in_ready, 1);
      chk("post_busy", busy, 0);
      chk("post_data_kept", out_data, exp_v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_w(0);
    for (int j = 0; j < D2; j++) bmem[j] = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {w_rd_en, b_rd_en}, 0);
    chk("rst_addrs", {w_addr, b_addr}, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", in_ready, 1);

    // Identity
    v = {16'd4, 16'd3, 16'd2, 16'd1};
    run_vec(v, 0);
    chk("ident_out", last_out, {16'd4, 16'd3, 16'd2, 16'd1});

    // Bias and ReLU clamp, issued back-to-back
    set_w(1);
    bmem[0] = 16'd0;
    bmem[1] = 16'hFFF0;
    bmem[2] = 16'd5;
    bmem[3] = 16'd0;
    v = {16'd1, 16'd1, 16'd1, 16'd1};
    run_vec(v, 0);
    chk("bias_out", last_out, {16'd4, 16'd9, 16'd0, 16'd4});

    // Product wraps modulo 2^16
    set_w(0);
    wmem[0] = 16'd4;
    for (int j = 0; j < D2; j++) bmem[j] = '0;
    v = {16'd0, 16'd0, 16'd0, 16'h4000};
    run_vec(v, 0);
    chk("wrap_out0", last_out[0], 0);

    // Backpressure with random data
    set_w(2);
    for (int j = 0; j < D2; j++) bmem[j] = NB'($urandom);
    v = vec_t'({$urandom, $urandom});
    run_vec(v, 5);

    // Reset in the middle of RUN
    set_w(0);
    for (int j = 0; j < D2; j++) bmem[j] = '0;
    in_valid = 1'b1;
    in_data  = {16'd9, 16'd9, 16'd9, 16'd9};
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_strobes", {w_rd_en, b_rd_en}, 0);
    chk("mrst_out_data", out_data, 0);
    v = {16'd4, 16'd3, 16'd2, 16'd1};
    run_vec(v, 0);
    chk("mrst_ident_out", last_out, {16'd4, 16'd3, 16'd2, 16'd1});

    // Back-to-back random vectors
    set_w(2);
    for (int j = 0; j < D2; j++) bmem[j] = NB'($urandom);
    v = vec_t'({$urandom, $urandom});
    run_vec(v, 0);
    v = vec_t'({$urandom, $urandom});
    run_vec(v, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dense_layer_sequencer.md
Name: dense_layer_sequencer

Overview:
Time-multiplexed dense layer: one shared multiply-accumulate unit computes dout[j] = ReLU(sum_i din[i]*W[i][j] + b[j]) for one input vector at a time.
Weights and biases are read from external synchronous memories rather than held as wide ports.
Sits between the feature front-end and the next MLP stage, using valid/ready on both sides.
Arithmetic results are bit-identical to the team's fully-parallel combinational dense layer.

Parameters:
NBits, 16, datapath word width (two's complement).
D1, 4, input vector length.
D2, 4, output vector length.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept a vector
in_data  in  NBits x [D1]  input vector
w_rd_en  out  1  weight read strobe
w_addr  out  $clog2(D1*D2)  weight address, i*D2+j
w_rdata  in  NBits  weight data, valid the cycle after w_rd_en
b_rd_en  out  1  bias read strobe
b_addr  out  $clog2(D2)  bias address j
b_rdata  in  NBits  bias data, valid the cycle after b_rd_en
out_valid  out  1  result vector valid
out_ready  in  1  downstream accepts result
out_data  out  NBits x [D2]  result vector
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset values: in_ready=0 during reset, then 1 in IDLE. out_valid=0, out_data all 0. w_rd_en=0, b_rd_en=0, w_addr=0, b_addr=0. busy=0. Accumulator 0. Counters 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data into an internal register, then go to RUN.
  - RUN: issue counter k runs 0..D1 within column j, for j = 0..D2-1.
    - k<D1: w_rd_en=1, w_addr=k*D2+j.
    - k==D1: b_rd_en=1, b_addr=j.
    - Each column takes D1+1 issue cycles; columns are issued back-to-back with no bubbles.
  - DRAIN: one cycle that consumes the final bias return.
  - DONE: out_valid=1.
- Return stage (registered one cycle behind issue):
  - Weight return: acc <= acc + trunc(x[k]*w_rdata).
  - Bias return: r = trunc(acc + b_rdata); out_data[j] <= r[NBits-1] ? 0 : r; acc <= 0 in the same edge.
- Width rules: every product and sum is truncated to NBits (wraps modulo 2^NBits). No saturation.
- Latency: handshake in cycle 0, N=D2*(D1+1).
  - Issues occur in cycles 1..N.
  - Last write lands at the end of cycle N+1.
  - out_valid=1 from cycle N+2. For D1=D2=4 that is cycle 22.
- Output hold: out_data and out_valid stay stable until out_valid&&out_ready. Then go to IDLE, with in_ready=1 the next cycle. out_data keeps its value; only out_valid drops.
- in_ready is 0 in RUN, DRAIN and DONE. No overlap between vectors. in_data changes while busy are ignored.
- out_ready high before DONE has no effect.
- Read strobes are 0 outside RUN. No two reads issue in the same cycle.
- Reset mid-operation: immediate return to IDLE with all reset values. In-flight read data arriving the next cycle is discarded.

Decomposition:
- Package mlp_pkg holds:
  - typedef word_t (logic [NBits-1:0]).
  - A relu function (MSB set gives 0).
  - The FSM state enum {IDLE, RUN, DRAIN, DONE}.
- Sub-module mlp_mac: registered accumulator with clear.
  - Inputs: a, b, en, bias_en, clr.
  - Output: the ReLU'd result.
  - The sequencer owns the FSM, counters, address generation and the output register file.

Test Plan:
- Identity: W[i][j]=(i==j), b=0, in_data={1,2,3,4} -> out_data={1,2,3,4}; out_valid first high in cycle 22 after the input handshake.
- Bias plus ReLU: W all 1, b={0,0xFFF0,5,0}, in_data={1,1,1,1} -> out_data={4,0,9,4}. Column 1 (4-16=-12) clamps to 0.
- Wrap: in_data[0]=0x4000, W[0][0]=4, other inputs 0, b=0 -> out_data[0]=0 (0x10000 truncated).
- Backpressure: out_ready held low for 5 cycles after out_valid -> out_data stable, in_ready=0, no read strobes; handshake on cycle 6, in_ready=1 the following cycle.
- Reset mid-RUN: assert rst at cycle 10 for 1 cycle -> next cycle out_valid=0, busy=0, in_ready=1, strobes 0. A following vector {1,2,3,4} with identity weights yields {1,2,3,4}.
- Back-to-back: two vectors presented with out_ready=1 continuously -> second accepted exactly 1 cycle after the first result handshake; each column's address sequence w_addr=j, D2+j, 2*D2+j, 3*D2+j, then b_addr=j.
